// File: rtl/mem_portb_arbiter_pkg.sv
// Shared definitions for the data-RAM port B arbiter: widths, requester IDs, FSM states.
package mem_portb_arbiter_pkg;
   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned MEM_WIDTH  = 8;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_IO  = 1'b1;

   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;
endpackage

// File: rtl/mem_dport_sclk.sv
// Dual-port single-clock RAM, read-first, registered outputs on both ports.
module mem_dport_sclk #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] data_a,
   output logic [DATA_WIDTH-1:0] out_a,
   input  logic                  we_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] data_b,
   output logic [DATA_WIDTH-1:0] out_b
);
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= data_a;
      if (we_b) mem[addr_b] <= data_b;
      out_a <= mem[addr_a];
      out_b <= mem[addr_b];
   end
endmodule

// File: rtl/mem_portb_arbiter.sv
// Port B arbiter: round-robin between CPU LSU (R0) and IO/debug (R1), bounded lock,
// and return of 1-cycle-latency read data to the requester that issued the read.
module mem_portb_arbiter #(
   parameter int unsigned DATA_WIDTH = mem_portb_arbiter_pkg::DATA_WIDTH,
   parameter int unsigned MEM_WIDTH  = mem_portb_arbiter_pkg::MEM_WIDTH,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_0,
   input  logic                  we_0,
   input  logic [MEM_WIDTH-1:0]  addr_0,
   input  logic [DATA_WIDTH-1:0] wdata_0,
   input  logic                  lock_0,
   output logic                  gnt_0,
   output logic                  rvalid_0,
   output logic [DATA_WIDTH-1:0] rdata_0,
   input  logic                  req_1,
   input  logic                  we_1,
   input  logic [MEM_WIDTH-1:0]  addr_1,
   input  logic [DATA_WIDTH-1:0] wdata_1,
   input  logic                  lock_1,
   output logic                  gnt_1,
   output logic                  rvalid_1,
   output logic [DATA_WIDTH-1:0] rdata_1,
   output logic                  mem_we,
   output logic [MEM_WIDTH-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   input  logic [DATA_WIDTH-1:0] mem_q
);
   import mem_portb_arbiter_pkg::*;

   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   state_t        state;
   logic          prio;
   logic          owner;
   logic          last_w;
   logic          rd_pend;
   logic          rd_id;
   logic [CW-1:0] burst_cnt;

   logic [1:0]    req;
   logic          win;
   logic          other;
   logic          gnt_any;
   logic          sel;
   logic          we_w;
   logic          lock_w;
   logic [CW-1:0] cnt_nxt;

   assign req = {req_1, req_0};

   always_comb begin
      win     = prio;
      gnt_any = 1'b0;
      if (state == ST_OPEN) begin
         if (req_0 && req_1) begin
            win     = prio;
            gnt_any = 1'b1;
         end else if (req_0) begin
            win     = REQ_CPU;
            gnt_any = 1'b1;
         end else if (req_1) begin
            win     = REQ_IO;
            gnt_any = 1'b1;
         end
      end else begin
         // A lock only stalls the other side while the owner is actually asking.
         if (req[owner]) begin
            win     = owner;
            gnt_any = 1'b1;
         end else if (req[~owner]) begin
            win     = ~owner;
            gnt_any = 1'b1;
         end
      end
      if (rst) gnt_any = 1'b0;

      other   = ~win;
      sel     = gnt_any ? win : last_w;
      we_w    = win ? we_1 : we_0;
      lock_w  = win ? lock_1 : lock_0;
      cnt_nxt = (burst_cnt == CW'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
   end

   assign gnt_0    = gnt_any && (win == REQ_CPU);
   assign gnt_1    = gnt_any && (win == REQ_IO);
   assign mem_we   = gnt_any && we_w;
   assign mem_addr = sel ? addr_1 : addr_0;
   assign mem_data = sel ? wdata_1 : wdata_0;
   assign rvalid_0 = rd_pend && (rd_id == REQ_CPU) && !rst;
   assign rvalid_1 = rd_pend && (rd_id == REQ_IO) && !rst;
   assign rdata_0  = mem_q;
   assign rdata_1  = mem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_OPEN;
         prio      <= REQ_CPU;
         owner     <= REQ_CPU;
         last_w    <= REQ_CPU;
         burst_cnt <= '0;
         rd_pend   <= 1'b0;
         rd_id     <= REQ_CPU;
      end else begin
         rd_pend <= gnt_any && !we_w;
         if (gnt_any) begin
            rd_id  <= win;
            last_w <= win;
            case (state)
               ST_OPEN: begin
                  prio  <= other;
                  owner <= win;
                  // The locking grant already counts as burst grant 1.
                  if (lock_w && !(req[other] && MAX_BURST == 1)) begin
                     state     <= ST_LOCKED;
                     burst_cnt <= CW'(1);
                  end
               end
               ST_LOCKED: begin
                  if (win == owner) begin
                     if (!lock_w || (req[other] && cnt_nxt == CW'(MAX_BURST))) begin
                        state     <= ST_OPEN;
                        prio      <= other;
                        burst_cnt <= '0;
                     end else begin
                        burst_cnt <= cnt_nxt;
                     end
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mem_portb_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/reads, a negedge monitor pops and compares.
module tb_mem_portb_arbiter;
   import mem_portb_arbiter_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  req_0, we_0, lock_0, req_1, we_1, lock_1;
   logic [MEM_WIDTH-1:0]  addr_0, addr_1;
   logic [DATA_WIDTH-1:0] wdata_0, wdata_1;
   logic                  gnt_0, gnt_1, rvalid_0, rvalid_1;
   logic [DATA_WIDTH-1:0] rdata_0, rdata_1;
   logic                  mem_we;
   logic [MEM_WIDTH-1:0]  mem_addr;
   logic [DATA_WIDTH-1:0] mem_data, mem_q, out_a;

   typedef struct {
      logic                  id;
      logic                  we;
      logic [MEM_WIDTH-1:0]  addr;
      logic [DATA_WIDTH-1:0] data;
   } g_exp_t;

   typedef struct {
      logic                  id;
      logic [DATA_WIDTH-1:0] data;
   } r_exp_t;

   g_exp_t gq[$];
   r_exp_t rq[$];
   g_exp_t ge;
   r_exp_t re;
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_portb_arbiter #(.DATA_WIDTH(DATA_WIDTH), .MEM_WIDTH(MEM_WIDTH), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0), .lock_0(lock_0),
      .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
      .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1), .lock_1(lock_1),
      .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q)
   );

   mem_dport_sclk #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(MEM_WIDTH)) ram (
      .clk(clk),
      .we_a(1'b0), .addr_a('0), .data_a('0), .out_a(out_a),
      .we_b(mem_we), .addr_b(mem_addr), .data_b(mem_data), .out_b(mem_q)
   );

   task automatic pg(input logic id, input logic we, input logic [MEM_WIDTH-1:0] a,
                     input logic [DATA_WIDTH-1:0] d);
      g_exp_t e;
      e.id = id; e.we = we; e.addr = a; e.data = d;
      gq.push_back(e);
   endtask

   task automatic pr(input logic id, input logic [DATA_WIDTH-1:0] d);
      r_exp_t e;
      e.id = id; e.data = d;
      rq.push_back(e);
   endtask

   task automatic step(input logic r0, input logic w0, input logic [MEM_WIDTH-1:0] a0,
                       input logic [DATA_WIDTH-1:0] d0, input logic l0,
                       input logic r1, input logic w1, input logic [MEM_WIDTH-1:0] a1,
                       input logic [DATA_WIDTH-1:0] d1, input logic l1);
      req_0 = r0; we_0 = w0; addr_0 = a0; wdata_0 = d0; lock_0 = l0;
      req_1 = r1; we_1 = w1; addr_1 = a1; wdata_1 = d1; lock_1 = l1;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (gnt_0 || gnt_1) begin
         checks++;
         if (gq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_gnt got gnt_1/gnt_0=%b%b expected none", gnt_1, gnt_0);
         end else begin
            ge = gq.pop_front();
            if ({gnt_1, gnt_0} !== (ge.id ? 2'b10 : 2'b01) || mem_we !== ge.we ||
                mem_addr !== ge.addr || (ge.we && mem_data !== ge.data)) begin
               failures++;
               $display("FAIL grant t=%0t got gnt=%b%b we=%b addr=%h data=%h expected id=%0d we=%b addr=%h data=%h",
                        $time, gnt_1, gnt_0, mem_we, mem_addr, mem_data, ge.id, ge.we, ge.addr, ge.data);
            end
         end
      end
      if (rvalid_0 || rvalid_1) begin
         checks++;
         if (rq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_rvalid got rvalid_1/rvalid_0=%b%b expected none", rvalid_1, rvalid_0);
         end else begin
            re = rq.pop_front();
            if ({rvalid_1, rvalid_0} !== (re.id ? 2'b10 : 2'b01) ||
                (re.id ? rdata_1 : rdata_0) !== re.data) begin
               failures++;
               $display("FAIL rvalid t=%0t got rvalid=%b%b rdata_0=%h rdata_1=%h expected id=%0d data=%h",
                        $time, rvalid_1, rvalid_0, rdata_0, rdata_1, re.id, re.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset held 2 cycles with both requesting: everything quiet.
      rst = 1'b1;
      req_0 = 1'b1; we_0 = 1'b1; addr_0 = 8'h10; wdata_0 = 16'h1111; lock_0 = 1'b0;
      req_1 = 1'b1; we_1 = 1'b1; addr_1 = 8'h20; wdata_1 = 16'h2222; lock_1 = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({gnt_1, gnt_0, mem_we, rvalid_1, rvalid_0} !== 5'b0) begin
            failures++;
            $display("FAIL reset_quiet got gnt=%b%b we=%b rvalid=%b%b expected all 0",
                     gnt_1, gnt_0, mem_we, rvalid_1, rvalid_0);
         end
         @(posedge clk);
      end
      #1;
      rst = 1'b0;

      // First cycle after reset: prio R0.
      pg(0, 1, 8'h10, 16'h1111);
      step(1, 1, 8'h10, 16'h1111, 0, 1, 1, 8'h20, 16'h2222, 0);
      pg(1, 1, 8'h20, 16'h2222);
      step(0, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h20, 16'h2222, 0);

      // Read latency on R1.
      pg(1, 1, 8'h03, 16'h5A5A);
      step(0, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h03, 16'h5A5A, 0);
      pg(1, 0, 8'h03, 16'h0000);
      pr(1, 16'h5A5A);
      step(0, 0, 8'h00, 16'h0000, 0, 1, 0, 8'h03, 16'h0000, 0);
      step(0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0);

      // Round-robin: R0 reads 0x10, R1 writes 0x30, alternating from R0.
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) begin
            pg(0, 0, 8'h10, 16'h0000);
            pr(0, 16'h1111);
         end else begin
            pg(1, 1, 8'h30, 16'h3333);
         end
         step(1, 0, 8'h10, 16'h0000, 0, 1, 1, 8'h30, 16'h3333, 0);
      end

      // Lock bound: four R0 grants, forced release to R1, then R0 relocks.
      for (int i = 0; i < 6; i++) begin
         if (i == 4) pg(1, 1, 8'h50, 16'h5555);
         else        pg(0, 1, 8'h40, 16'h4444);
         step(1, 1, 8'h40, 16'h4444, 1, 1, 1, 8'h50, 16'h5555, 0);
      end

      // Lock yield: owner idle, R1 served; owner still wins when both request.
      pg(1, 1, 8'h60, 16'h6666);
      step(0, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h60, 16'h6666, 0);
      pg(0, 1, 8'h41, 16'h4141);
      step(1, 1, 8'h41, 16'h4141, 0, 1, 1, 8'h61, 16'h6161, 0);
      pg(1, 1, 8'h61, 16'h6161);
      step(0, 0, 8'h00, 16'h0000, 0, 1, 1, 8'h61, 16'h6161, 0);

      // Reset mid-read: no rvalid for the read granted just before reset.
      pg(0, 0, 8'h40, 16'h0000);
      step(1, 0, 8'h40, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0);
      rst = 1'b1;
      req_0 = 1'b0; req_1 = 1'b0;
      @(negedge clk);
      checks++;
      if (rvalid_0 !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_read got rvalid_0=%b expected 0", rvalid_0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      pg(0, 1, 8'h70, 16'h7070);
      step(1, 1, 8'h70, 16'h7070, 0, 1, 1, 8'h71, 16'h7171, 0);
      pg(1, 1, 8'h71, 16'h7171);
      step(1, 1, 8'h70, 16'h7070, 0, 1, 1, 8'h71, 16'h7171, 0);
      step(0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0);
      step(0, 0, 8'h00, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0);

      checks++;
      if (gq.size() != 0) begin
         failures++;
         $display("FAIL gnt_drain got %0d grants outstanding expected 0", gq.size());
      end
      checks++;
      if (rq.size() != 0) begin
         failures++;
         $display("FAIL rvalid_drain got %0d reads outstanding expected 0", rq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
